// File: rtl/m3_uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the M3 fabric-side UART
//               receiver: FSM state encoding, frame data width and default
//               bit periods for the 54 MHz and 324 MHz clock domains.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS = 8;

    // 54 MHz / 115200 and 324 MHz / 115200, rounded to the nearest cycle
    localparam int CLKS_PER_BIT_54M  = 469;
    localparam int CLKS_PER_BIT_324M = 2813;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        STOP     = 3'd3,
        BRK_WAIT = 3'd4
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/m3_uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : m3_uart_rx_if
// Description : Byte delivery interface of the UART receiver.
//               master : receiver side (drives data/valid/status)
//               slave  : consumer side (drives rx_ready)
//   rx_data   [8] received byte, LSB = first data bit
//   rx_valid  [1] rx_data holds an unconsumed byte
//   rx_ready  [1] consumer accepts rx_data when rx_valid && rx_ready
//   busy      [1] a frame is in progress
//   frame_err [1] one-cycle pulse, stop bit sampled low
//   overrun   [1] one-cycle pulse, completed byte dropped (buffer full)
// Revision    : 1.0 - initial release
// ============================================================================
interface m3_uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 busy;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        output busy,
        output frame_err,
        output overrun
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        input  busy,
        input  frame_err,
        input  overrun
    );

endinterface
`default_nettype wire

// File: rtl/m3_uart_rx_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous input bit.
//   clk     in  destination clock
//   reset_n in  synchronous active-low reset, loads RESET_VAL into both flops
//   d       in  asynchronous input
//   q       out synchronized output
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic d,
    output logic      q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/m3_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : m3_uart_rx
// Description : 8N1 UART receiver for the Cortex-M3 UART0 TX line. Bytes are
//               handed to fabric logic through a one-entry holding buffer
//               with a valid/ready handshake; framing errors and overruns are
//               reported as single-cycle pulses.
//   clk     in  system clock
//   reset_n in  synchronous active-low reset
//   rxd     in  asynchronous serial line, idle high
//   rx_if   master modport: rx_data, rx_valid, rx_ready, busy, frame_err,
//           overrun
// Revision    : 1.0 - initial release
// ============================================================================
module m3_uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_54M
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    input  wire logic     rxd,
    m3_uart_rx_if.master  rx_if
);

    // Start bit is confirmed at its centre; all later samples are a full bit
    // period apart, landing at bit centre +/- 1 cycle.
    localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam int BW       = $clog2(DATA_BITS);

    localparam logic [CW-1:0] c_half     = CW'(HALF_BIT);
    localparam logic [CW-1:0] c_last     = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] c_last_bit = BW'(DATA_BITS - 1);

    logic                 w_rxs;
    rx_state_t            r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_deliver;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_frame_err;
    logic                 r_overrun;

    // Synchronizer resets to the idle (high) line level so that leaving
    // reset never looks like a start edge.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rxd (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rxd),
        .q       (w_rxs)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_deliver   <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_deliver   <= 1'b0;

            // Holding buffer: a completed byte lands one cycle after the
            // stop-bit sample. A consume in that same cycle frees the slot.
            if (r_deliver) begin
                if (!r_valid || rx_if.rx_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_if.rx_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!w_rxs) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end

                START: begin
                    if (r_cnt == c_half) begin
                        r_cnt <= '0;
                        if (!w_rxs) begin
                            r_state <= DATA;
                            r_bit   <= '0;
                        end else begin
                            // Low pulse shorter than half a bit: noise
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (r_cnt == c_last) begin
                        r_cnt          <= '0;
                        r_shift[r_bit] <= w_rxs;
                        if (r_bit == c_last_bit) begin
                            r_state <= STOP;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (r_cnt == c_last) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            // Return at mid-stop so a start edge half a bit
                            // later (zero idle gap) is caught.
                            r_deliver <= 1'b1;
                            r_state   <= IDLE;
                            r_busy    <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= BRK_WAIT;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                BRK_WAIT: begin
                    // Hold off until the line idles so a break is not
                    // decoded as a stream of 0x00 frames.
                    r_cnt <= '0;
                    if (w_rxs) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.rx_data   = r_data;
    assign rx_if.rx_valid  = r_valid;
    assign rx_if.busy      = r_busy;
    assign rx_if.frame_err = r_frame_err;
    assign rx_if.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: doc/m3_uart_rx.md
Name: m3_uart_rx

Overview:
- Fabric-side 8N1 UART receiver that listens to the line driven by the Cortex-M3 UART0 transmitter (uart0_txd).
- Lets FPGA logic receive byte commands from M3 firmware alongside the existing GPIO path.
- Delivers each received byte over a valid/ready handshake with a one-entry holding buffer.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 469, clk cycles per bit (54 MHz / 115200, rounded); legal range is 8 or more.
- HALF_BIT, (CLKS_PER_BIT-1)/2, start-bit mid-point sample offset (derived; do not override).

Ports:
- clk  in  1  system clock (54 MHz M3 domain)
- reset_n  in  1  synchronous, active-low reset
- rxd  in  1  serial line from M3 uart0_txd; asynchronous; idle high
- rx_data  out  8  received byte, LSB = first data bit
- rx_valid  out  1  rx_data holds an unconsumed byte
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready
- busy  out  1  a frame is in progress (state != IDLE)
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: completed byte dropped because the buffer was full

Behaviour:
- Reset (reset_n=0 at a clk edge) applies the following:
  - state=IDLE, bit counter=0, cycle counter=0.
  - Synchronizer flops=1.
  - rx_data=0, rx_valid=0, busy=0, frame_err=0, overrun=0.
  - Reset mid-frame abandons the frame; no pulse is generated.
- Input path: rxd goes through a 2-FF synchronizer (rxs). All decisions use rxs.
- Cycle counter cnt: width $clog2(CLKS_PER_BIT). Cleared on every state entry.
- FSM transitions:
  - IDLE: rxs==0 -> START, cnt=0.
  - START: when cnt==HALF_BIT, sample rxs. If 0 -> DATA with bit index=0; if 1 -> IDLE (glitch rejected, no pulse).
  - DATA: when cnt==CLKS_PER_BIT-1, sample rxs into shift[bit index] (LSB first). After index 7 -> STOP.
  - STOP: when cnt==CLKS_PER_BIT-1, sample rxs.
    - If 1: deliver the byte, then -> IDLE.
    - If 0: pulse frame_err, discard the byte, -> BRK_WAIT.
  - BRK_WAIT: stay until rxs==1, then -> IDLE. This prevents a break or stuck-low line from being decoded as repeated 0x00 frames.
- Sample points: each data bit and the stop bit are sampled CLKS_PER_BIT cycles after the previous sample, i.e. at bit centre ±1 cycle.
- Delivery happens in the cycle after the STOP sample:
  - rx_valid==0: load rx_data, set rx_valid=1.
  - rx_valid==1 && rx_ready==1 in that same cycle: old byte is consumed, new byte loaded, rx_valid stays 1.
  - rx_valid==1 && rx_ready==0: pulse overrun, keep the old rx_data, drop the new byte.
- Handshake rules:
  - rx_valid clears the cycle after rx_valid && rx_ready, unless a new byte loads in that same cycle.
  - rx_data is stable while rx_valid=1 and not accepted.
- busy=1 in START, DATA, STOP and BRK_WAIT.
- Latency: rx_valid rises 3 clk after the rxd transition that follows the stop-bit centre sample (2 sync flops + 1 register stage).
- Back-to-back frames: after STOP the FSM returns to IDLE at mid-stop-bit. A start edge occurring 0.5 bit later is detected. Zero idle gap between frames must work.

Decomposition:
- Package uart_pkg:
  - state enum: IDLE, START, DATA, STOP, BRK_WAIT.
  - DATA_BITS=8.
  - Default CLKS_PER_BIT localparams for 54 MHz and 324 MHz clocks (469, 2813).
- One sub-module: sync_2ff (1-bit, reset value parameterized to 1), reusable for key inputs.

Test Plan (CLKS_PER_BIT=16 for simulation):
- Single frame: send 0xA5, rx_ready=1 -> one rx_valid pulse with rx_data=0xA5, frame_err=0, overrun=0; busy high for about 9.5 bit times.
- Back-to-back: 0x00, 0xFF, 0x55 with no idle gap -> three deliveries in order, no errors.
- Glitch: rxd low for 5 cycles, then high -> FSM returns to IDLE, no rx_valid, no frame_err.
- Framing error: send 0x3C with stop bit=0, line held low for 40 cycles, then high -> single frame_err pulse, no rx_valid, busy until rxd returns high; the next 0x81 is received correctly.
- Overrun: rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 retained, one overrun pulse at the second delivery; raising rx_ready then yields rx_valid=0 the next cycle.
- Reset mid-frame: reset_n=0 for 1 cycle during DATA bit 3 -> all outputs 0, state IDLE; the next frame 0xC3 decodes correctly.
